// File: rtl/hci_package.sv
// Shared types for the HCI copy-sink fault monitor.
package hci_package;

   typedef enum logic [1:0] {
      MONITOR  = 2'd0,
      ALARM    = 2'd1,
      CLEAR    = 2'd2,
      ACK_WAIT = 2'd3
   } hci_fault_mon_state_e;

endpackage

// File: rtl/hci_sat_counter.sv
// Saturating up-counter; clr_i restarts the count from inc_i instead of from q.
module hci_sat_counter #(
   parameter int Width    = 8,
   parameter int IncWidth = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic [IncWidth-1:0] inc_i,
   output logic [Width-1:0]    q_o
);

   // One extra bit over the wider operand so the add can never wrap before the clamp.
   localparam int SumW = ((Width > IncWidth) ? Width : IncWidth) + 1;
   localparam logic [SumW-1:0] MaxVal = SumW'({Width{1'b1}});

   logic [Width-1:0] q_q, q_d;
   logic [SumW-1:0]  sum;

   always_comb begin
      sum = (clr_i ? '0 : SumW'(q_q)) + SumW'(inc_i);
      q_d = (sum > MaxVal) ? '1 : sum[Width-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/hci_copy_fault_monitor.sv
// Collects copy-sink fault flags into sticky status, saturating counters and a
// first-source record; raises a threshold alarm cleared by a four-phase handshake.
module hci_copy_fault_monitor
   import hci_package::*;
#(
   parameter  int NumSources  = 4,
   parameter  int CntWidth    = 8,
   localparam int SrcIdxWidth = (NumSources > 1) ? $clog2(NumSources) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumSources-1:0]          fault_i,
   input  logic [NumSources-1:0]          mask_i,
   input  logic [CntWidth-1:0]            threshold_i,
   input  logic                           clear_req_i,
   output logic                           clear_ack_o,
   output logic [NumSources-1:0]          fault_sticky_o,
   output logic [NumSources*CntWidth-1:0] fault_cnt_o,
   output logic [CntWidth-1:0]            total_cnt_o,
   output logic                           first_valid_o,
   output logic [SrcIdxWidth-1:0]         first_src_o,
   output logic                           alarm_o,
   output logic                           irq_o
);

   localparam int IncW = $clog2(NumSources + 1);
   localparam int SumW = ((CntWidth > IncW) ? CntWidth : IncW) + 1;
   localparam logic [SumW-1:0] MaxCnt = SumW'({CntWidth{1'b1}});

   hci_fault_mon_state_e state_q, state_d;
   logic [NumSources-1:0]  eff;
   logic                   clr;
   logic [IncW-1:0]        popcnt;
   logic [SumW-1:0]        tot_sum;
   logic [CntWidth-1:0]    next_total;
   logic [CntWidth-1:0]    thr;
   logic                   alarm_cond;
   logic [NumSources-1:0]  sticky_q, sticky_d;
   logic                   first_valid_q, first_valid_d;
   logic [SrcIdxWidth-1:0] first_src_q, first_src_d;
   logic                   alarm_q, alarm_d, ack_q, ack_d, irq_q, irq_d;

   assign eff = fault_i & ~mask_i;
   assign clr = (state_q == CLEAR);

   generate
      for (genvar gi = 0; gi < NumSources; gi++) begin : g_src_cnt
         hci_sat_counter #(
            .Width    (CntWidth),
            .IncWidth (1)
         ) u_src_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr),
            .inc_i (eff[gi]),
            .q_o   (fault_cnt_o[gi*CntWidth +: CntWidth])
         );
      end
   endgenerate

   hci_sat_counter #(
      .Width    (CntWidth),
      .IncWidth (IncW)
   ) u_total_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr),
      .inc_i (popcnt),
      .q_o   (total_cnt_o)
   );

   // The alarm compares against the count the total counter is about to load,
   // so alarm_o rises together with the crossing value.
   always_comb begin
      popcnt = '0;
      for (int k = 0; k < NumSources; k++) popcnt = popcnt + IncW'(eff[k]);
      tot_sum    = (clr ? '0 : SumW'(total_cnt_o)) + SumW'(popcnt);
      next_total = (tot_sum > MaxCnt) ? '1 : tot_sum[CntWidth-1:0];
      thr        = (threshold_i == '0) ? CntWidth'(1) : threshold_i;
      alarm_cond = (next_total >= thr);
   end

   always_comb begin
      sticky_d      = clr ? eff : (sticky_q | eff);
      first_valid_d = clr ? 1'b0 : first_valid_q;
      first_src_d   = clr ? '0 : first_src_q;
      if (!first_valid_d && (eff != '0)) begin
         first_valid_d = 1'b1;
         for (int k = NumSources - 1; k >= 0; k--) begin
            if (eff[k]) first_src_d = SrcIdxWidth'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MONITOR: begin
            if (clear_req_i)     state_d = CLEAR;
            else if (alarm_cond) state_d = ALARM;
         end
         ALARM:    if (clear_req_i) state_d = CLEAR;
         CLEAR:    state_d = ACK_WAIT;
         ACK_WAIT: if (!clear_req_i) state_d = alarm_cond ? ALARM : MONITOR;
         default:  state_d = MONITOR;
      endcase
      alarm_d = (state_d == ALARM);
      ack_d   = (state_d == CLEAR) || (state_d == ACK_WAIT);
      irq_d   = (state_d == ALARM) && (state_q != ALARM);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= MONITOR;
         sticky_q      <= '0;
         first_valid_q <= 1'b0;
         first_src_q   <= '0;
         alarm_q       <= 1'b0;
         ack_q         <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         sticky_q      <= sticky_d;
         first_valid_q <= first_valid_d;
         first_src_q   <= first_src_d;
         alarm_q       <= alarm_d;
         ack_q         <= ack_d;
         irq_q         <= irq_d;
      end
   end

   assign fault_sticky_o = sticky_q;
   assign first_valid_o  = first_valid_q;
   assign first_src_o    = first_src_q;
   assign alarm_o        = alarm_q;
   assign clear_ack_o    = ack_q;
   assign irq_o          = irq_q;

endmodule

// File: tb/tb_hci_copy_fault_monitor.sv
// Directed bench: a default monitor plus a 2-bit-counter instance for saturation.
module tb_hci_copy_fault_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: NumSources=4, CntWidth=8
   logic        rst, req;
   logic [3:0]  fault, mask;
   logic [7:0]  thr;
   logic        ack, first_valid, alarm, irq;
   logic [3:0]  sticky;
   logic [31:0] cnt;
   logic [7:0]  total;
   logic [1:0]  first_src;

   // instance B: NumSources=4, CntWidth=2
   logic        b_rst;
   logic [3:0]  b_fault;
   logic [1:0]  b_thr;
   logic        b_ack, b_first_valid, b_alarm, b_irq;
   logic [3:0]  b_sticky;
   logic [7:0]  b_cnt;
   logic [1:0]  b_total;
   logic [1:0]  b_first_src;

   int total_n = 0;
   int bad_n   = 0;

   hci_copy_fault_monitor #(.NumSources(4), .CntWidth(8)) dut (
      .clk_i(clk), .rst_i(rst), .fault_i(fault), .mask_i(mask),
      .threshold_i(thr), .clear_req_i(req), .clear_ack_o(ack),
      .fault_sticky_o(sticky), .fault_cnt_o(cnt), .total_cnt_o(total),
      .first_valid_o(first_valid), .first_src_o(first_src),
      .alarm_o(alarm), .irq_o(irq)
   );

   hci_copy_fault_monitor #(.NumSources(4), .CntWidth(2)) dut_b (
      .clk_i(clk), .rst_i(b_rst), .fault_i(b_fault), .mask_i(4'b0000),
      .threshold_i(b_thr), .clear_req_i(1'b0), .clear_ack_o(b_ack),
      .fault_sticky_o(b_sticky), .fault_cnt_o(b_cnt), .total_cnt_o(b_total),
      .first_valid_o(b_first_valid), .first_src_o(b_first_src),
      .alarm_o(b_alarm), .irq_o(b_irq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_n++;
      assert (obs === exp) else begin
         bad_n++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; fault = '0; mask = '0; thr = 8'd3;
      b_rst = 1'b1; b_fault = '0; b_thr = 2'd3;
      step();
      rst = 1'b0; b_rst = 1'b0;
      repeat (20) step();
      chk("idle_cnt",    cnt, 32'h0);
      chk("idle_total",  total, 8'h0);
      chk("idle_sticky", sticky, 4'h0);
      chk("idle_fvalid", first_valid, 1'b0);
      chk("idle_fsrc",   first_src, 2'd0);
      chk("idle_alarm",  alarm, 1'b0);
      chk("idle_irq",    irq, 1'b0);
      chk("idle_ack",    ack, 1'b0);

      // source 2 faults three cycles with threshold 3
      fault = 4'b0100;
      step();
      chk("s2_cnt1",   cnt, 32'h0001_0000);
      chk("s2_fsrc",   first_src, 2'd2);
      chk("s2_fvalid", first_valid, 1'b1);
      chk("s2_alarm1", alarm, 1'b0);
      step();
      chk("s2_cnt2",   cnt, 32'h0002_0000);
      chk("s2_alarm2", alarm, 1'b0);
      step();
      chk("s2_cnt3",   cnt, 32'h0003_0000);
      chk("s2_alarm3", alarm, 1'b1);
      chk("s2_irq3",   irq, 1'b1);
      fault = 4'b0000;
      step();
      chk("s2_irq_off",  irq, 1'b0);
      chk("s2_alarm_hd", alarm, 1'b1);
      chk("s2_sticky",   sticky, 4'b0100);

      // clear handshake with a fault arriving in the CLEAR cycle
      req = 1'b1;
      step();
      chk("clr_ack",     ack, 1'b1);
      chk("clr_alarm",   alarm, 1'b0);
      fault = 4'b0001;
      step();
      fault = 4'b0000;
      chk("clr_cnt",     cnt, 32'h0000_0001);
      chk("clr_total",   total, 8'd1);
      chk("clr_fsrc",    first_src, 2'd0);
      chk("clr_fvalid",  first_valid, 1'b1);
      chk("clr_sticky",  sticky, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ack_hold", ack, 1'b1);
      end
      req = 1'b0;
      step();
      chk("ack_drop",    ack, 1'b0);
      chk("ack_alarm",   alarm, 1'b0);
      chk("ack_irq",     irq, 1'b0);

      // simultaneous faults: lowest unmasked index wins
      rst = 1'b1; step(); rst = 1'b0;
      fault = 4'b1010; mask = 4'b0000;
      step();
      fault = 4'b0000;
      chk("m0_total", total, 8'd2);
      chk("m0_fsrc",  first_src, 2'd1);
      rst = 1'b1; step(); rst = 1'b0;
      fault = 4'b1010; mask = 4'b0010;
      step();
      fault = 4'b0000; mask = 4'b0000;
      chk("m1_total",  total, 8'd1);
      chk("m1_fsrc",   first_src, 2'd3);
      chk("m1_sticky", sticky, 4'b1000);
      chk("m1_cnt",    cnt, 32'h0100_0000);

      // threshold 0 acts as 1; lowering it below the total alarms next cycle
      thr = 8'd0;
      step();
      chk("thr0_alarm", alarm, 1'b1);
      chk("thr0_irq",   irq, 1'b1);
      step();
      chk("thr0_irq2",  irq, 1'b0);

      // reset in the middle of the handshake
      req = 1'b1;
      step();
      step();
      chk("aw_ack",   ack, 1'b1);
      chk("aw_total", total, 8'd0);
      rst = 1'b1; req = 1'b0;
      step();
      rst = 1'b0;
      chk("rst_ack",    ack, 1'b0);
      chk("rst_total",  total, 8'd0);
      chk("rst_fvalid", first_valid, 1'b0);
      chk("rst_alarm",  alarm, 1'b0);
      thr = 8'd3;
      step();
      chk("rst_idle_alarm", alarm, 1'b0);
      chk("rst_idle_ack",   ack, 1'b0);

      // 2-bit counters saturate without wrapping
      b_fault = 4'b1111;
      step();
      chk("b_cnt1",   b_cnt, 8'h55);
      chk("b_total1", b_total, 2'd3);
      chk("b_alarm1", b_alarm, 1'b1);
      chk("b_irq1",   b_irq, 1'b1);
      step();
      chk("b_cnt2",   b_cnt, 8'hAA);
      chk("b_irq2",   b_irq, 1'b0);
      step();
      chk("b_cnt3",   b_cnt, 8'hFF);
      step();
      b_fault = 4'b0000;
      chk("b_cnt4",   b_cnt, 8'hFF);
      chk("b_total4", b_total, 2'd3);
      chk("b_fsrc",   b_first_src, 2'd0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/hci_copy_fault_monitor.md
Name: hci_copy_fault_monitor

Overview:
Downstream collector for the registered fault flags produced by a set of HCI copy-sink comparators (one flag per protected HCI chain). It holds sticky per-source status, per-source and total saturating fault counters, and the identity of the first faulting source. When the total fault count reaches a programmable threshold it raises an alarm and a one-cycle interrupt. The alarm stays up until software clears it through a four-phase request/acknowledge handshake.

Parameters:
NumSources, 4, number of monitored copy-sink fault flags (>=1)
CntWidth, 8, width of every fault counter and of the threshold (>=2)
SrcIdxWidth, max(1,$clog2(NumSources)), width of the first-source index (derived, not overridden)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
fault_i  input  NumSources  registered fault flags from copy sinks, level per cycle
mask_i  input  NumSources  1 = ignore that source (not counted, not sticky, not first)
threshold_i  input  CntWidth  alarm threshold on total count; 0 is treated as 1
clear_req_i  input  1  clear request, four-phase level
clear_ack_o  output  1  clear acknowledge
fault_sticky_o  output  NumSources  sticky unmasked fault per source
fault_cnt_o  output  NumSources*CntWidth  per-source saturating counts; source k at bits [k*CntWidth +: CntWidth]
total_cnt_o  output  CntWidth  saturating sum of all counted faults
first_valid_o  output  1  first_src_o holds a valid value
first_src_o  output  SrcIdxWidth  index of first faulting source
alarm_o  output  1  high while in ALARM state
irq_o  output  1  one-cycle pulse on entry to ALARM

Behaviour:
- Reset (rst_i high at a clock edge, any state): all counters 0, sticky 0, first_valid_o 0, first_src_o 0, state MONITOR; all outputs 0 from the next cycle. Reset mid-handshake drops the ack immediately.
- Effective faults: eff = fault_i & ~mask_i, sampled every cycle in every state.
- Counting, latency 1: eff in cycle N is visible on counters/sticky in N+1.
  - Per-source counter: +1 where eff[k]=1, saturates at 2^CntWidth-1.
  - Total counter: + popcount(eff), saturating; no wrap under any multi-bit add.
  - Sticky: OR-accumulate.
- First source: captured when first_valid_o=0 and eff!=0. Lowest set index wins on simultaneous faults. Held until clear.
- Threshold: thr = (threshold_i==0) ? 1 : threshold_i. The alarm condition is next_total >= thr, so alarm_o rises in the same cycle the crossing count becomes visible.
- FSM states: MONITOR, ALARM, CLEAR, ACK_WAIT.
  - MONITOR: if clear_req_i -> CLEAR (clear has priority over the alarm condition); else if alarm condition -> ALARM.
  - ALARM: alarm_o=1; on clear_req_i -> CLEAR.
  - CLEAR (exactly one cycle): clear_ack_o=1. Counters, sticky and first are reloaded from that cycle's eff, as if starting from zero, so no fault is lost. Next state ACK_WAIT.
  - ACK_WAIT: clear_ack_o=1 while clear_req_i=1, counting continues. When clear_req_i=0: clear_ack_o drops; go to ALARM if total >= thr, else MONITOR.
- irq_o is high only in the first cycle of ALARM (registered entry-edge), including a re-entry from ACK_WAIT.
- alarm_o=1 only in ALARM; clear_ack_o=1 only in CLEAR and ACK_WAIT.
- threshold_i changing is honoured on the next comparison. Lowering it below the current total in MONITOR raises the alarm next cycle.
- mask_i takes effect on the same cycle's sample and never alters stored values.

Decomposition:
- hci_package: add typedef enum logic [1:0] hci_fault_mon_state_e {MONITOR, ALARM, CLEAR, ACK_WAIT}.
- Sub-module hci_sat_counter (parameters Width, IncWidth; ports clk_i, rst_i, clr_i, inc_i, q_o; saturating add with clear-and-load). Instantiated once per source plus once for the total.

Test Plan:
- Reset then idle 20 cycles, fault_i=0 -> all outputs 0, state MONITOR.
- NumSources=4, threshold_i=3, fault_i=4'b0100 for 3 cycles -> cnt[2]=1,2,3; first_src_o=2, first_valid_o=1; alarm_o and irq_o rise on the cycle cnt[2]=3; irq_o low the next cycle.
- fault_i=4'b1010 for one cycle with mask_i=4'b0000 -> total_cnt_o=2, first_src_o=1. Repeat with mask_i=4'b0010 -> total_cnt_o=1, first_src_o=3.
- CntWidth=2, fault_i=4'b1111 for 3 cycles, threshold_i=3 -> all counters saturate at 3, no wrap; alarm after cycle 1.
- In ALARM, assert clear_req_i while fault_i=4'b0001 in the CLEAR cycle -> clear_ack_o high; cnt[0]=1, total=1, first_src_o=0. Hold req 4 cycles -> ack held. Drop req -> ack low next cycle, MONITOR (thr=3).
- Assert rst_i during ACK_WAIT -> next cycle clear_ack_o=0, counters 0, MONITOR.
